// File: rtl/la5_matrix_loader.sv
// rtl/la5_matrix_loader.sv - 5x5 matrix frame loader and read port for the LA5 core
//
// Buffers one row-major frame of N*N elements, flags it to LA5 and holds it
// frozen until LA5 releases it.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous active-low reset
//   in_data        write-stream element (row-major a11..a55)
//   in_valid       in_data valid this cycle
//   in_last        final element of the frame, qualified by in_valid
//   in_ready       loader accepts in_data this cycle
//   address        read index from LA5 (0..N*N-1)
//   data_out       registered read data for address (0 when out of range)
//   matrix_valid   a complete, well-formed matrix is held
//   matrix_release one-cycle pulse from LA5: matrix consumed
//   frame_err      one-cycle pulse: framing violation, frame discarded
//   wr_count       elements accepted so far in the current frame

module la5_matrix_loader #(
  parameter int DW = 32,
  parameter int N  = 5,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  input  logic          in_last,
  output logic          in_ready,
  input  logic [AW-1:0] address,
  output logic [DW-1:0] data_out,
  output logic          matrix_valid,
  input  logic          matrix_release,
  output logic          frame_err,
  output logic [AW-1:0] wr_count
);

  localparam int            DEPTH     = N * N;
  localparam logic [AW-1:0] LAST_SLOT = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_W   = (AW + 1)'(DEPTH);

  typedef enum logic {LOAD, FULL} state_t;

  state_t        state_q, state_d;
  logic          armed_q;
  logic [AW-1:0] count_q, count_d;
  logic          err_d;
  logic          wr_en;
  logic          transfer;
  logic [DW-1:0] mem [DEPTH];

  // armed_q keeps in_ready low until the first edge after reset deasserts.
  assign in_ready     = armed_q && (state_q == LOAD);
  assign matrix_valid = (state_q == FULL);
  assign wr_count     = count_q;
  assign transfer     = in_valid && in_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= LOAD;
      armed_q   <= 1'b0;
      count_q   <= '0;
      frame_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      armed_q   <= 1'b1;
      count_q   <= count_d;
      frame_err <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    err_d   = 1'b0;
    wr_en   = 1'b0;
    case (state_q)
      LOAD: begin
        if (transfer) begin
          // in_last must coincide exactly with the final slot; any other
          // combination discards the word and restarts the frame.
          if ((count_q == LAST_SLOT) != in_last) begin
            err_d   = 1'b1;
            count_d = '0;
          end else if (in_last) begin
            wr_en   = 1'b1;
            count_d = '0;
            state_d = FULL;
          end else begin
            wr_en   = 1'b1;
            count_d = count_q + AW'(1);
          end
        end
      end
      FULL: begin
        if (matrix_release) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  // Buffer contents survive reset; only matrix_valid qualifies them.
  always_ff @(posedge clk) begin
    if (wr_en) mem[count_q] <= in_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out <= '0;
    end else if ({1'b0, address} < DEPTH_W) begin
      data_out <= mem[address];
    end else begin
      data_out <= '0;
    end
  end

endmodule

// File: tb/tb_la5_matrix_loader.sv
// tb/tb_la5_matrix_loader.sv - self-checking bench for la5_matrix_loader

module tb_la5_matrix_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [4:0]  address;
  logic [31:0] data_out;
  logic        matrix_valid;
  logic        matrix_release;
  logic        frame_err;
  logic [4:0]  wr_count;

  int checks = 0;
  int errors = 0;

  la5_matrix_loader dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .address(address),
    .data_out(data_out), .matrix_valid(matrix_valid),
    .matrix_release(matrix_release), .frame_err(frame_err), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: buffer contents, frame position, and held/armed flags.
  logic [31:0] m_mem [25];
  bit          m_known [25];
  int          m_pos;
  bit          m_full, m_armed, m_err, m_dknown;
  logic [31:0] m_dout;

  initial for (int i = 0; i < 25; i++) m_known[i] = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_full = 0; m_armed = 0; m_err = 0; m_pos = 0;
      m_dout = 0; m_dknown = 1;
    end else begin
      if (int'(address) < 25) begin
        m_dout   = m_mem[address];
        m_dknown = m_known[address];
      end else begin
        m_dout   = 0;
        m_dknown = 1;
      end
      m_err = 0;
      if (m_full) begin
        if (matrix_release) m_full = 0;
      end else if (m_armed && in_valid) begin
        if (bit'(in_last) != (m_pos == 24)) begin
          m_err = 1;
          m_pos = 0;
        end else begin
          m_mem[m_pos]   = in_data;
          m_known[m_pos] = 1;
          if (in_last) begin
            m_full = 1;
            m_pos  = 0;
          end else begin
            m_pos = m_pos + 1;
          end
        end
      end
      m_armed = 1;
    end
  end

  bit run_cmp = 0;
  always @(negedge clk) begin
    if (run_cmp) begin
      chk("in_ready", {31'b0, in_ready}, {31'b0, m_armed && !m_full});
      chk("matrix_valid", {31'b0, matrix_valid}, {31'b0, m_full});
      chk("frame_err", {31'b0, frame_err}, {31'b0, m_err});
      chk("wr_count", {27'b0, wr_count}, m_pos);
      if (m_dknown) chk("data_out", data_out, m_dout);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] d, input logic last, input bit gap);
    in_data  = d;
    in_valid = 1'b1;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (gap) tick();
  endtask

  task automatic load_frame(input logic [31:0] base, input bit gap);
    for (int i = 0; i < 25; i++) send_word(base + i, (i == 24), gap);
  endtask

  task automatic pulse_release();
    matrix_release = 1'b1;
    tick();
    matrix_release = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

  initial begin
    reset = 1'b0; in_data = '0; in_valid = 1'b0; in_last = 1'b0;
    address = '0; matrix_release = 1'b0;
    #1;
    chk("rst_ready", {31'b0, in_ready}, 0);
    chk("rst_valid", {31'b0, matrix_valid}, 0);
    chk("rst_err", {31'b0, frame_err}, 0);
    chk("rst_count", {27'b0, wr_count}, 0);
    chk("rst_dout", data_out, 0);
    #11 reset = 1'b1;
    #1 chk("ready_before_edge", {31'b0, in_ready}, 0);
    run_cmp = 1;
    tick();
    chk("ready_after_edge", {31'b0, in_ready}, 1);

    // Scenario 1: back-to-back clean frame and full read sweep
    load_frame(32'h10, 0);
    chk("s1_valid", {31'b0, matrix_valid}, 1);
    chk("s1_ready", {31'b0, in_ready}, 0);
    for (int a = 0; a < 26; a++) begin
      address = 5'(a);
      tick();
      chk("s1_sweep", data_out, (a < 25) ? 32'h10 + a : 32'h0);
    end

    // Scenario 2: writes ignored while FULL, then release and reload
    address = 5'd0;
    in_data = 32'hDEADBEEF;
    in_valid = 1'b1;
    repeat (3) tick();
    in_valid = 1'b0;
    tick();
    chk("s2_frozen", data_out, 32'h10);
    pulse_release();
    chk("s2_rel_valid", {31'b0, matrix_valid}, 0);
    chk("s2_rel_ready", {31'b0, in_ready}, 1);
    load_frame(32'h100, 0);
    chk("s2_valid", {31'b0, matrix_valid}, 1);
    address = 5'd7;
    tick();
    chk("s2_read7", data_out, 32'h107);
    pulse_release();

    // Scenario 3: early in_last on the 10th word
    for (int i = 0; i < 10; i++) send_word(32'h500 + i, (i == 9), 0);
    chk("s3_err", {31'b0, frame_err}, 1);
    chk("s3_count", {27'b0, wr_count}, 0);
    chk("s3_valid", {31'b0, matrix_valid}, 0);
    tick();
    chk("s3_err_gone", {31'b0, frame_err}, 0);
    load_frame(32'h200, 0);
    chk("s3_valid_after", {31'b0, matrix_valid}, 1);
    pulse_release();

    // Scenario 4: 25 words with no in_last
    for (int i = 0; i < 25; i++) send_word(32'h600 + i, 1'b0, 0);
    chk("s4_err", {31'b0, frame_err}, 1);
    chk("s4_count", {27'b0, wr_count}, 0);
    chk("s4_valid", {31'b0, matrix_valid}, 0);
    tick();

    // Scenario 5: mid-cycle reset after 12 words, then in FULL
    address = 5'd0;
    for (int i = 0; i < 12; i++) send_word(32'h300 + i, 1'b0, 0);
    chk("s5_count12", {27'b0, wr_count}, 12);
    chk("s5_dout_pre", data_out, 32'h300);
    #2 reset = 1'b0;
    #1;
    chk("s5_rst_ready", {31'b0, in_ready}, 0);
    chk("s5_rst_count", {27'b0, wr_count}, 0);
    chk("s5_rst_dout", data_out, 0);
    tick();
    reset = 1'b1;
    tick();
    load_frame(32'h400, 0);
    chk("s5_valid", {31'b0, matrix_valid}, 1);
    #2 reset = 1'b0;
    #1 chk("s5_full_rst", {31'b0, matrix_valid}, 0);
    tick();
    reset = 1'b1;
    tick();

    // Scenario 6: gapped frame, then release together with in_valid
    load_frame(32'h10, 1);
    chk("s6_valid", {31'b0, matrix_valid}, 1);
    for (int a = 0; a < 25; a += 6) begin
      address = 5'(a);
      tick();
      chk("s6_sweep", data_out, 32'h10 + a);
    end
    address = 5'd0;
    in_data = 32'h999;
    in_valid = 1'b1;
    matrix_release = 1'b1;
    tick();
    in_valid = 1'b0;
    matrix_release = 1'b0;
    chk("s6_rel_valid", {31'b0, matrix_valid}, 0);
    chk("s6_rel_ready", {31'b0, in_ready}, 1);
    chk("s6_rel_count", {27'b0, wr_count}, 0);
    tick();
    chk("s6_mem0", data_out, 32'h10);

    run_cmp = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
